// File: rtl/pulsador_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : pulsador_debouncer
// Brief    : Synchronizes raw push-buttons/switches, debounces each button
//            and emits one-hot press pulses with a latched switch snapshot.
// Revision : 1.0  initial release
// ============================================================================
module pulsador_debouncer #(
    parameter int N_BITS_DATA      = 8,
    parameter int N_PULSADORES     = 3,
    parameter int N_CICLOS_ESTABLE = 1000000,
    parameter int N_BITS_CONTADOR  = 20
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_PULSADORES-1:0] i_pulsadores,
    input  logic [N_BITS_DATA-1:0]  i_switches,
    output logic [N_PULSADORES-1:0] o_pulsadores,
    output logic [N_BITS_DATA-1:0]  o_switches,
    output logic                    o_conflicto
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [N_BITS_CONTADOR-1:0] c_cnt_max =
        N_BITS_CONTADOR'(N_CICLOS_ESTABLE - 1);

    logic [N_PULSADORES-1:0] r_puls_s1;
    logic [N_PULSADORES-1:0] r_puls_s2;
    logic [N_BITS_DATA-1:0]  r_sw_s1;
    logic [N_BITS_DATA-1:0]  r_sw_s2;

    logic [N_PULSADORES-1:0] w_req;
    logic                    w_any;
    logic                    w_multi;
    logic                    w_seen;

    logic [N_PULSADORES-1:0] r_pulsadores;
    logic [N_BITS_DATA-1:0]  r_switches;
    logic                    r_conflicto;

    // Two-flop synchronizers; only the second stage feeds the logic below.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_puls_s1 <= '0;
            r_puls_s2 <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
        end else begin
            r_puls_s1 <= i_pulsadores;
            r_puls_s2 <= r_puls_s1;
            r_sw_s1   <= i_switches;
            r_sw_s2   <= r_sw_s1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_PULSADORES; k++) begin : g_button
            state_t                     r_state;
            state_t                     w_state_next;
            logic [N_BITS_CONTADOR-1:0] r_cnt;
            logic [N_BITS_CONTADOR-1:0] w_cnt_next;
            logic                       w_done;

            assign w_done   = (r_cnt == c_cnt_max);
            // Request is combinational so the output register fires on the
            // very edge that accepts the press.
            assign w_req[k] = (r_state == PRESS_WAIT) && r_puls_s2[k] && w_done;

            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    IDLE: begin
                        if (r_puls_s2[k]) begin
                            w_state_next = PRESS_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!r_puls_s2[k]) begin
                            w_state_next = IDLE;
                        end else if (w_done) begin
                            w_state_next = PRESSED;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!r_puls_s2[k]) begin
                            w_state_next = RELEASE_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (r_puls_s2[k]) begin
                            w_state_next = PRESSED;
                        end else if (w_done) begin
                            w_state_next = IDLE;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end
        end
    endgenerate

    // Flags two or more simultaneous requests.
    always_comb begin
        w_multi = 1'b0;
        w_seen  = 1'b0;
        for (int i = 0; i < N_PULSADORES; i++) begin
            if (w_req[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    assign w_any = |w_req;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pulsadores <= '0;
            r_switches   <= '0;
            r_conflicto  <= 1'b0;
        end else begin
            r_conflicto <= w_multi;
            if (w_any && !w_multi) begin
                r_pulsadores <= w_req;
                r_switches   <= r_sw_s2;
            end else begin
                r_pulsadores <= '0;
            end
        end
    end

    assign o_pulsadores = r_pulsadores;
    assign o_switches   = r_switches;
    assign o_conflicto  = r_conflicto;

endmodule
`default_nettype wire

// File: tb/tb_pulsador_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulsador_debouncer
// Brief    : Directed self-checking bench for pulsador_debouncer (window = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_pulsador_debouncer;

    logic       clk;
    logic       rst;
    logic [2:0] pul_in;
    logic [7:0] sw_in;
    logic [2:0] pul_out;
    logic [7:0] sw_out;
    logic       confl;

    int n_checks = 0;
    int n_pass   = 0;

    pulsador_debouncer #(
        .N_BITS_DATA      (8),
        .N_PULSADORES     (3),
        .N_CICLOS_ESTABLE (4),
        .N_BITS_CONTADOR  (3)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_pulsadores (pul_in),
        .i_switches   (sw_in),
        .o_pulsadores (pul_out),
        .o_switches   (sw_out),
        .o_conflicto  (confl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pul_in = 3'b000;
        sw_in  = 8'h00;
        step();
        step();
        n_checks++;
        if (pul_out !== 3'b000) $display("FAIL reset_pulsadores got=%b exp=000", pul_out);
        else n_pass++;
        n_checks++;
        if (sw_out !== 8'h00) $display("FAIL reset_switches got=%h exp=00", sw_out);
        else n_pass++;
        n_checks++;
        if (confl !== 1'b0) $display("FAIL reset_conflicto got=%b exp=0", confl);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        sw_in  = 8'h5A;
        pul_in = 3'b001;
        for (int e = 1; e <= 20; e++) begin
            step();
            exp = (e == 7) ? 3'b001 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL clean_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            n_checks++;
            if (confl !== 1'b0) $display("FAIL clean_conflicto edge=%0d got=%b exp=0", e, confl);
            else n_pass++;
            if (e == 6) begin
                n_checks++;
                if (sw_out !== 8'h00) $display("FAIL clean_sw_before got=%h exp=00", sw_out);
                else n_pass++;
            end
            if (e == 7) begin
                n_checks++;
                if (sw_out !== 8'h5A) $display("FAIL clean_sw_latch got=%h exp=5a", sw_out);
                else n_pass++;
            end
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_checks++;
            if (pul_out !== 3'b000) $display("FAIL clean_release edge=%0d got=%b exp=000", e, pul_out);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp;
        logic [5:0] pattern;
        pattern = 6'b101101;  // applied MSB first: 1,0,1,1,0,1
        sw_in   = 8'hC3;
        for (int e = 1; e <= 25; e++) begin
            pul_in = (e <= 6) ? {1'b0, pattern[6-e], 1'b0} : 3'b010;
            step();
            exp = (e == 12) ? 3'b010 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL bounce_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            if (e == 12) begin
                n_checks++;
                if (sw_out !== 8'hC3) $display("FAIL bounce_sw got=%h exp=c3", sw_out);
                else n_pass++;
            end
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 10; e++) step();
    endtask

    task automatic test_release_glitch();
        logic [2:0] exp;
        sw_in  = 8'h81;
        pul_in = 3'b100;
        for (int e = 1; e <= 25; e++) begin
            step();
            exp = (e == 7) ? 3'b100 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL glitch_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            // two low cycles sampled on edges 11 and 12, then high again
            if (e == 10) pul_in = 3'b000;
            if (e == 12) pul_in = 3'b100;
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 8; e++) step();
        sw_in  = 8'h7E;
        pul_in = 3'b100;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp = (e == 7) ? 3'b100 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL repress_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            if (e == 7) begin
                n_checks++;
                if (sw_out !== 8'h7E) $display("FAIL repress_sw got=%h exp=7e", sw_out);
                else n_pass++;
            end
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 10; e++) step();
    endtask

    task automatic test_simultaneous();
        logic exp_c;
        sw_in  = 8'h33;
        pul_in = 3'b011;
        for (int e = 1; e <= 12; e++) begin
            step();
            exp_c = (e == 7);
            n_checks++;
            if (pul_out !== 3'b000) $display("FAIL simul_pulse edge=%0d got=%b exp=000", e, pul_out);
            else n_pass++;
            n_checks++;
            if (confl !== exp_c) $display("FAIL simul_conflicto edge=%0d got=%b exp=%b", e, confl, exp_c);
            else n_pass++;
            n_checks++;
            if (sw_out !== 8'h7E) $display("FAIL simul_sw_hold edge=%0d got=%h exp=7e", e, sw_out);
            else n_pass++;
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 10; e++) step();
    endtask

    task automatic test_staggered();
        logic [2:0] exp;
        sw_in  = 8'h11;
        pul_in = 3'b001;
        for (int e = 1; e <= 22; e++) begin
            step();
            exp = (e == 7) ? 3'b001 : (e == 17) ? 3'b100 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL stagger_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            n_checks++;
            if (confl !== 1'b0) $display("FAIL stagger_conflicto edge=%0d got=%b exp=0", e, confl);
            else n_pass++;
            if (e == 7) begin
                n_checks++;
                if (sw_out !== 8'h11) $display("FAIL stagger_sw0 got=%h exp=11", sw_out);
                else n_pass++;
            end
            if (e == 17) begin
                n_checks++;
                if (sw_out !== 8'h22) $display("FAIL stagger_sw2 got=%h exp=22", sw_out);
                else n_pass++;
            end
            if (e == 10) begin
                pul_in = 3'b101;
                sw_in  = 8'h22;
            end
        end
        pul_in = 3'b000;
        for (int e = 1; e <= 10; e++) step();
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        pul_in = 3'b001;
        // after edge 5 the FSM sits in PRESS_WAIT with cnt == 2
        for (int e = 1; e <= 5; e++) step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (sw_out !== 8'h00) $display("FAIL rstmid_sw_async got=%h exp=00", sw_out);
        else n_pass++;
        n_checks++;
        if (pul_out !== 3'b000) $display("FAIL rstmid_pulse_async got=%b exp=000", pul_out);
        else n_pass++;
        n_checks++;
        if (confl !== 1'b0) $display("FAIL rstmid_conflicto_async got=%b exp=0", confl);
        else n_pass++;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            step();
            exp = (e == 7) ? 3'b001 : 3'b000;
            n_checks++;
            if (pul_out !== exp) $display("FAIL rstmid_pulse edge=%0d got=%b exp=%b", e, pul_out, exp);
            else n_pass++;
            if (e == 7) begin
                n_checks++;
                if (sw_out !== 8'h22) $display("FAIL rstmid_sw got=%h exp=22", sw_out);
                else n_pass++;
            end
        end
        pul_in = 3'b000;
    endtask

    initial begin
        rst    = 1'b1;
        pul_in = 3'b000;
        sw_in  = 8'h00;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_staggered();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulsador_debouncer.md
Name: pulsador_debouncer

Overview:
Input-conditioning stage that sits directly upstream of the ALU operand/opcode loader. It synchronizes the raw board push-buttons and switches and debounces each button with a counter. It emits a single-cycle, one-hot press pulse per debounced press. On that same cycle it presents a latched, stable copy of the switches, so the loader captures clean data exactly once per press.

Parameters:
N_BITS_DATA, 8, width of switch bus and latched switch output
N_PULSADORES, 3, number of push-buttons
N_CICLOS_ESTABLE, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz)
N_BITS_CONTADOR, 20, debounce counter width; must satisfy 2^N_BITS_CONTADOR >= N_CICLOS_ESTABLE

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous, active-high reset
i_pulsadores  input  N_PULSADORES  raw, bouncy, asynchronous buttons (1 = pressed)
i_switches  input  N_BITS_DATA  raw asynchronous switches
o_pulsadores  output  N_PULSADORES  one-cycle press pulses, at most one bit high per cycle
o_switches  output  N_BITS_DATA  synchronized switches, latched on each valid press pulse
o_conflicto  output  1  one-cycle pulse when two or more buttons would pulse on the same cycle

Behaviour:
- Reset (async assert, synchronous release):
  - all sync flops, counters and outputs go to 0
  - every button FSM goes to IDLE
  - o_pulsadores=0, o_switches=0, o_conflicto=0
- Synchronizers: each button bit and each switch bit passes through 2 flops (s1, s2). Only s2 is used downstream.
- Per-button FSM, 4 states, counter cnt[k]:
  - IDLE (stable released): s2=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - s2=0 -> IDLE (glitch, no pulse).
    - s2=1 and cnt==N_CICLOS_ESTABLE-1 -> PRESSED and raise press request.
    - otherwise cnt+1.
  - PRESSED (stable pressed): s2=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT:
    - s2=1 -> PRESSED (glitch, no new pulse).
    - s2=0 and cnt==N_CICLOS_ESTABLE-1 -> IDLE.
    - otherwise cnt+1.
- Counter saturation: cnt never exceeds N_CICLOS_ESTABLE-1. It is cleared on every entry to a WAIT state.
- Latency: count the first rising edge that samples raw=1 as edge 1. The press request, and so the registered pulse, is visible after edge N_CICLOS_ESTABLE+3, provided raw stays high throughout.
- Pulse length: exactly 1 cycle per accepted press, regardless of how long the button is held. No auto-repeat.
- Output register, on each edge:
  - Exactly one request -> o_pulsadores = that one-hot bit, o_conflicto=0, o_switches <= s2 switches (same edge).
  - Two or more requests -> o_pulsadores=0, o_conflicto=1, o_switches unchanged.
  - No request -> o_pulsadores=0, o_conflicto=0, o_switches holds.
- Data alignment: o_switches already holds the value latched with a pulse during that pulse's cycle. The downstream loader sampling at the next edge sees consistent data.
- Independence: FSMs are independent. One button held in PRESSED does not block a press on another button.
- Button held across reset release: its FSM starts in IDLE, so after release it produces exactly one pulse after the normal latency.
- Reset mid-debounce: the press is discarded and no pulse is produced until a full stable window completes after reset.

Test Plan:
- Clean press, N_CICLOS_ESTABLE=4, i_switches=8'h5A, button[0] rises and is held 20 cycles -> o_pulsadores=3'b001 for exactly 1 cycle after edge 7; o_switches=8'h5A on that cycle; no further pulse while held.
- Bounce, N_CICLOS_ESTABLE=4, button[1] pattern 1,0,1,1,0,1 then steady 1 -> single 3'b010 pulse only after 4 consecutive synchronized highs; no pulse during the bounce.
- Release glitch: button[2] held until pulsed, then 2 cycles low, then high again -> no second pulse. A full release (≥4 low) followed by a re-press -> a second 3'b100 pulse.
- Simultaneous: button[0] and button[1] rise on the same edge, i_switches=8'h33 -> o_pulsadores stays 0; o_conflicto=1 for 1 cycle; o_switches keeps its previous value.
- Staggered: button[0] held, then button[2] pressed 10 cycles later -> two separate one-hot pulses (001, then 100), each latching the i_switches value present at its own pulse.
- Reset mid-operation: assert i_reset asynchronously while button[0] is in PRESS_WAIT with cnt=2 -> all outputs 0 immediately. Button still held after release -> exactly one pulse, N_CICLOS_ESTABLE+3 edges after reset release.
